// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the fifo_thresh buffer and the
// register-map wrappers built around it.
//   fifo_depth()     - depth in entries for a given log2 size
//   FIFO_CNT_MAX_W   - count width for the largest legal FIFO_SIZE (16)
//   fifo_status_t    - occupancy snapshot {count, almost_full, almost_empty}
package fifo_pkg;

  localparam int FIFO_SIZE_MAX  = 16;
  localparam int FIFO_CNT_MAX_W = FIFO_SIZE_MAX + 1;

  function automatic int fifo_depth(input int fifo_size);
    return 1 << fifo_size;
  endfunction

  // Sized for the widest legal FIFO; wrappers zero-extend count_o into it.
  typedef struct packed {
    logic [FIFO_CNT_MAX_W-1:0] count;
    logic                      almost_full;
    logic                      almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: storage array for fifo_thresh. Contents are not reset.
// Ports:
//   clk_i  - clock, write on rising edge
//   we_i   - write enable
//   waddr_i, wdata_i - write address / data
//   raddr_i - read address
//   rdata_o - read data, combinational from the array (asynchronous read)
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  import fifo_pkg::*;

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_thresh.sv
// fifo_thresh: synchronous FIFO with valid/ready on both sides, occupancy
// count, programmable almost-full / almost-empty flags and synchronous flush.
// Optional feature macro: FIFO_THRESH_BYPASS_EN (zero-latency pass-through
// when the FIFO is empty).
// Ports:
//   arst_ni        - asynchronous reset, active low
//   clk_i          - clock
//   flush_i        - synchronous flush, discards all entries
//   data_i / data_i_valid_i / data_i_ready_o - write side
//   data_o / data_o_valid_o / data_o_ready_i - read side
//   count_o        - occupancy 0..DEPTH
//   almost_full_o  - count_o >= ALMOST_FULL_TH
//   almost_empty_o - count_o <= ALMOST_EMPTY_TH
module fifo_thresh
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_SIZE       = 4,
  parameter int ALMOST_FULL_TH  = 2**FIFO_SIZE - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  arst_ni,
  input  logic                  clk_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_i_valid_i,
  output logic                  data_i_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_o_valid_o,
  input  logic                  data_o_ready_i,
  output logic [FIFO_SIZE:0]    count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int DEPTH = fifo_depth(FIFO_SIZE);
  localparam int PW    = FIFO_SIZE + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_TH_C = PW'(ALMOST_FULL_TH);
  localparam logic [PW-1:0] AE_TH_C = PW'(ALMOST_EMPTY_TH);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  if (FIFO_SIZE < 1 || FIFO_SIZE > FIFO_SIZE_MAX) begin : g_bad_size
    $error("fifo_thresh: FIFO_SIZE must be in 1..16");
  end
  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af
    $error("fifo_thresh: ALMOST_FULL_TH must be in 1..DEPTH");
  end
  if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_thresh: ALMOST_EMPTY_TH must be in 0..DEPTH-1");
  end

  // MSB of each pointer is the wrap bit, so wr - rd is the occupancy.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [PW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  byp_take;
  logic                  valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (FIFO_SIZE)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q[FIFO_SIZE-1:0]),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q[FIFO_SIZE-1:0]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    full  = (count == DEPTH_C);
    empty = (count == '0);

    // Ready depends only on pointer state and flush, never on the consumer,
    // so a push on full is refused even when a pop happens the same cycle.
    data_i_ready_o = !full && !flush_i;

`ifdef FIFO_THRESH_BYPASS_EN
    // Empty FIFO: present the incoming word directly. If the consumer takes
    // it, nothing is stored; otherwise it is written as a normal push.
    if (empty && !flush_i) begin
      valid    = data_i_valid_i;
      byp_take = data_i_valid_i && data_o_ready_i;
      data_o   = data_i_valid_i ? data_i : '0;
    end else begin
      valid    = !empty && !flush_i;
      byp_take = 1'b0;
      data_o   = valid ? mem_rdata : '0;
    end
`else
    valid    = !empty && !flush_i;
    byp_take = 1'b0;
    data_o   = valid ? mem_rdata : '0;
`endif

    data_o_valid_o = valid;
    push = data_i_valid_i && data_i_ready_o && !byp_take;
    // Pointer pop only when a stored entry is consumed; a bypassed word never
    // touched the array.
    pop  = !empty && !flush_i && data_o_ready_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ONE_C;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE_C;
    end

    count_o        = count;
    almost_full_o  = (count >= AF_TH_C);
    almost_empty_o = (count <= AE_TH_C);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_thresh.sv
// Directed bench for fifo_thresh (DEPTH=4, AF=3, AE=1). Expected read data is
// queued by the stimulus; a negedge monitor pops and compares on every read
// handshake. Occupancy and flags are checked against hand-computed values.
module tb_fifo_thresh;

`ifdef FIFO_THRESH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       rst_n;
  logic       clk;
  logic       flush;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [2:0] count;
  logic       af;
  logic       ae;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  fifo_thresh #(
    .DATA_WIDTH      (8),
    .FIFO_SIZE       (2),
    .ALMOST_FULL_TH  (3),
    .ALMOST_EMPTY_TH (1)
  ) dut (
    .arst_ni        (rst_n),
    .clk_i          (clk),
    .flush_i        (flush),
    .data_i         (din),
    .data_i_valid_i (din_valid),
    .data_i_ready_o (din_ready),
    .data_o         (dout),
    .data_o_valid_o (dout_valid),
    .data_o_ready_i (dout_ready),
    .count_o        (count),
    .almost_full_o  (af),
    .almost_empty_o (ae)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read-side scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        chk("read_data", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    din_valid  = v;
    din        = d;
    dout_ready = r;
    flush      = f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input int c);
    chk({tag, "_count"}, 32'(count), 32'(c));
    chk({tag, "_af"},    32'(af),    32'(c >= 3));
    chk({tag, "_ae"},    32'(ae),    32'(c <= 1));
  endtask

  logic [7:0] vals [5];

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset state, then idle after release.
    @(negedge clk);
    chk("rst_ready", 32'(din_ready), 1);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_data",  32'(dout), 0);
    chk_status("rst", 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(din_ready), 1);
    chk("idle_valid", 32'(dout_valid), 0);
    chk("idle_data",  32'(dout), 0);
    chk_status("idle", 0);
    next_cycle();

    // Fill with consumer stalled; 5th write refused.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b0);
      if (i < 4) exp_q.push_back(vals[i]);
      @(negedge clk);
      chk_status("fill", i);
      chk("fill_ready", 32'(din_ready), 32'(i < 4));
      next_cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk_status("full_hold", 4);
    chk("full_valid", 32'(dout_valid), 1);
    next_cycle();

    // Full with both sides active: pop only, then push accepted next cycle.
    drive(1'b1, 8'h66, 1'b1, 1'b0);
    @(negedge clk);
    chk("full_pp_ready", 32'(din_ready), 0);
    chk_status("full_pp", 4);
    next_cycle();
    exp_q.push_back(8'h66);
    @(negedge clk);
    chk("after_pop_ready", 32'(din_ready), 1);
    chk_status("after_pop", 3);
    next_cycle();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int c = 3; c > 0; c--) begin
      @(negedge clk);
      chk_status("drain", c);
      next_cycle();
    end
    @(negedge clk);
    chk_status("drained", 0);
    chk("drained_valid", 32'(dout_valid), 0);
    chk("drained_queue", 32'(exp_q.size()), 0);

    // Streaming push+pop: pointers wrap several times, count constant.
    next_cycle();
    for (int k = 0; k < 21; k++) begin
      drive(1'b1, 8'(k * 37 + 3), (k != 0) || BYP, 1'b0);
      exp_q.push_back(8'(k * 37 + 3));
      @(negedge clk);
      if (k > 0) chk("stream_count", 32'(count), BYP ? 0 : 1);
      next_cycle();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk("stream_end_count", 32'(count), 0);
    chk("stream_queue", 32'(exp_q.size()), 0);
    next_cycle();

    // Flush at count 3 with a write attempted.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
      exp_q.push_back(8'(8'hA1 + i));
      next_cycle();
    end
    drive(1'b1, 8'hEE, 1'b1, 1'b1);
    @(negedge clk);
    chk_status("pre_flush", 3);
    chk("flush_ready", 32'(din_ready), 0);
    chk("flush_valid", 32'(dout_valid), 0);
    exp_q.delete();
    next_cycle();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk_status("post_flush", 0);
    chk("post_flush_valid", 32'(dout_valid), 0);
    chk("post_flush_data",  32'(dout), 0);
    next_cycle();
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    exp_q.push_back(8'hA5);
    next_cycle();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk_status("a5", 1);
    chk("a5_valid", 32'(dout_valid), 1);
    next_cycle();
    @(negedge clk);
    chk("a5_queue", 32'(exp_q.size()), 0);
    next_cycle();

    // Single word into empty FIFO with consumer ready: bypass vs. latency.
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    exp_q.push_back(8'h5A);
    @(negedge clk);
    chk("w5a_valid_same", 32'(dout_valid), 32'(BYP));
    next_cycle();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("w5a_count_next", 32'(count), BYP ? 0 : 1);
    chk("w5a_valid_next", 32'(dout_valid), BYP ? 0 : 1);
    next_cycle();
    @(negedge clk);
    chk("w5a_count_end", 32'(count), 0);
    chk("w5a_queue", 32'(exp_q.size()), 0);

    // Asynchronous reset mid-transfer discards stored data.
    next_cycle();
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    chk("mid_count", 32'(count), 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_valid", 32'(dout_valid), 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk_status("after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
